// File: rtl/mont_mul.sv
// mont_mul: radix-2 bit-serial Montgomery multiplier.
// Computes result = A_i * B_i * 2^-WIDTH mod Prime in WIDTH+3 cycles per
// operation (capture, WIDTH iterations, correction, output).
//
// Ports:
//   clk     - clock, rising edge active
//   reset   - asynchronous active-high reset
//   in_sig  - start strobe, sampled only while idle
//   A_i     - multiplicand (Montgomery domain)
//   B_i     - multiplier (Montgomery domain), reduced once by Prime on capture
//   Prime   - odd modulus, held stable for the whole operation
//   result  - registered product, valid while done is high, held until next op
//   busy    - high whenever an operation is in flight
//   done    - one-cycle completion pulse
module mont_mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_sig,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic [WIDTH-1:0] Prime,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned SW = WIDTH + 1;  // accumulator, holds values < 2P
    localparam int unsigned TW = WIDTH + 2;  // iteration sum, holds values < 4P
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        CORR,
        OUT
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [SW-1:0]    s_reg;

    logic [TW-1:0]    t_acc;
    logic [TW-1:0]    t_odd;
    logic [SW-1:0]    s_next;
    logic [SW-1:0]    p_ext;
    logic             s_ge_p;

    // One Montgomery step: add B if the current A bit is set, make the sum
    // even by adding P, then halve. No bits are dropped before the shift.
    always_comb begin
        t_acc  = TW'(s_reg) + (a_reg[cnt] ? TW'(b_reg) : '0);
        t_odd  = t_acc[0] ? (t_acc + TW'(Prime)) : t_acc;
        s_next = t_odd[TW-1:1];
        p_ext  = SW'(Prime);
        s_ge_p = (s_reg >= p_ext);
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            s_reg  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (in_sig) begin
                        a_reg <= A_i;
                        b_reg <= (B_i >= Prime) ? (B_i - Prime) : B_i;
                        s_reg <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    s_reg <= s_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST_ITER) begin
                        state <= CORR;
                    end
                end
                CORR: begin
                    // Accumulator is < 2P, so one conditional subtract suffices.
                    result <= s_ge_p ? WIDTH'(s_reg - p_ext) : s_reg[WIDTH-1:0];
                    done   <= 1'b1;
                    state  <= OUT;
                end
                OUT: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_mul.sv
// tb_mont_mul: self-checking bench for mont_mul (WIDTH = 32).
// Reference: reduce A*B fully mod P with wide arithmetic, then divide by
// 2^32 mod P through 32 modular halvings.
module tb_mont_mul;

    logic        clk;
    logic        reset;
    logic        in_sig;
    logic [31:0] A_i;
    logic [31:0] B_i;
    logic [31:0] Prime;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int n_total;
    int n_bad;

    mont_mul #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .in_sig (in_sig),
        .A_i    (A_i),
        .B_i    (B_i),
        .Prime  (Prime),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A*B*2^-32 mod P, for odd P.
    function automatic logic [31:0] mont_ref(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] p);
        logic [127:0] prod;
        logic [63:0]  x;
        prod = 128'(a) * 128'(b);
        x    = 64'(prod % 128'(p));
        for (int i = 0; i < 32; i++) begin
            if (x[0]) x = x + 64'(p);
            x = x >> 1;
        end
        return 32'(x);
    endfunction

    // Run one operation; checks latency, result (optional), result stability
    // during the computation and the done pulse width.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                          input logic [31:0] exp_res, input bit do_res, input string tag);
        int          lat;
        bit          stable;
        logic [31:0] prev;
        @(negedge clk);
        A_i = a; B_i = b; Prime = p; in_sig = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_sig = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        prev   = result;
        stable = 1'b1;
        lat    = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
            if (result !== prev) stable = 1'b0;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd33);
        chk({tag, "_hold"}, 64'(stable), 64'd1);
        if (do_res) chk({tag, "_res"}, 64'(result), 64'(exp_res));
        @(posedge clk); #1;
        chk({tag, "_donew"}, 64'(done), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] a, b, p;
        int          pulses, first_lat, edge_no;
        int          d_edges[$];

        n_total = 0; n_bad = 0;
        reset = 1'b1; in_sig = 1'b0; A_i = '0; B_i = '0; Prime = 32'd13;
        #2;
        chk("rst_res", 64'(result), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors.
        run_op(32'd1, 32'd1, 32'd13, 32'd3, 1'b1, "p13_1x1");
        run_op(32'd9, 32'd9, 32'd13, 32'd9, 1'b1, "p13_9x9");
        run_op(32'd1, 32'd14, 32'd13, 32'd3, 1'b1, "p13_prered");
        run_op(32'd0, 32'd5, 32'd13, 32'd0, 1'b1, "a_zero");
        run_op(32'd7, 32'd13, 32'd13, 32'd0, 1'b1, "b_zero_red");
        run_op(32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 32'hCCCC_CCC9, 1'b1, "carry");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               mont_ref(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b1, "pmax");
        run_op(32'd5, 32'd6, 32'd12, 32'd0, 1'b0, "even_p");

        // Random, large odd moduli (B < 2P always holds).
        for (int i = 0; i < 12; i++) begin
            p = $urandom | 32'h8000_0001;
            a = $urandom;
            b = $urandom;
            run_op(a, b, p, mont_ref(a, b, p), 1'b1, $sformatf("rnd_big%0d", i));
        end
        // Random, small odd moduli with B limited below 2P.
        for (int i = 0; i < 8; i++) begin
            p = 32'($urandom_range(3, 2000)) | 32'd1;
            a = $urandom;
            b = 32'($urandom_range(0, 2 * int'(p) - 1));
            run_op(a, b, p, mont_ref(a, b, p), 1'b1, $sformatf("rnd_small%0d", i));
        end

        // Start strobe during CALC is ignored.
        @(negedge clk);
        A_i = 32'd1; B_i = 32'd1; Prime = 32'd13; in_sig = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_sig = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        in_sig = 1'b1;
        @(negedge clk);
        in_sig = 1'b0;
        pulses = 0; first_lat = 0;
        for (int k = 12; k < 80; k++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (first_lat == 0) begin
                    first_lat = k;
                    chk("ign_res", 64'(result), 64'd3);
                    @(posedge clk); #1;
                    k++;
                    chk("ign_gap", 64'(busy), 64'd0);
                end
            end
        end
        chk("ign_pulses", 64'(pulses), 64'd1);
        chk("ign_lat", 64'(first_lat), 64'd33);

        // in_sig held high: back-to-back operations 35 cycles apart.
        @(negedge clk);
        A_i = 32'd9; B_i = 32'd9; Prime = 32'd13; in_sig = 1'b1;
        edge_no = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            edge_no++;
            if (done) begin
                d_edges.push_back(edge_no);
                chk($sformatf("held_res%0d", d_edges.size()), 64'(result), 64'd9);
                if (d_edges.size() == 2) break;
            end
        end
        @(negedge clk);
        in_sig = 1'b0;
        chk("held_cnt", 64'(d_edges.size()), 64'd2);
        if (d_edges.size() == 2) begin
            chk("held_first", 64'(d_edges[0]), 64'd34);
            chk("held_gap", 64'(d_edges[1] - d_edges[0]), 64'd35);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("held_idle", 64'(busy), 64'd0);

        // Reset mid-CALC aborts with no done and clears result immediately.
        @(negedge clk);
        A_i = 32'd1; B_i = 32'd1; Prime = 32'd13; in_sig = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_sig = 1'b0;
        repeat (16) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_res", 64'(result), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("abort_nodone", 64'(pulses), 64'd0);
        chk("abort_hold", 64'(result), 64'd0);
        run_op(32'd9, 32'd9, 32'd13, 32'd9, 1'b1, "restart");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
